// File: rtl/encode_pkg.sv
// encode_pkg: shared types and constants for the LZS code-word encoder.
//   tok_e   - input token kinds (literal / match / end / reserved)
//   state_e - encoder FSM states
//   LZS prefix constants, end-marker value and field widths.
package encode_pkg;

  localparam int CODE_W = 13;  // widest code word (long-offset match)
  localparam int LEN_W  = 4;   // code length field
  localparam int OFF_W  = 11;  // offset / length field width

  typedef enum logic [1:0] {
    TOK_LIT   = 2'b00,
    TOK_MATCH = 2'b01,
    TOK_END   = 2'b10,
    TOK_RSVD  = 2'b11
  } tok_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LEN  = 2'b01,
    ST_EXT  = 2'b10
  } state_e;

  localparam logic       LIT_PFX   = 1'b0;     // literal: 0 + byte
  localparam logic [1:0] OFF7_PFX  = 2'b11;    // offset < 128
  localparam logic [1:0] OFF11_PFX = 2'b10;    // offset >= 128
  localparam logic [8:0] END_MARK  = 9'h180;   // 110000000
  localparam logic [3:0] NIB_ONES  = 4'hF;

  localparam logic [OFF_W-1:0] EXT_MIN_LEN = 11'd23;  // length where E reaches 15
  localparam logic [OFF_W-1:0] EXT_STEP    = 11'd45;  // three full nibbles

endpackage

// File: rtl/encode_code.sv
// encode_code: converts literal/match/end tokens into LZS code words for a
// downstream bit packer. One code word per cycle at most, one-cycle latency.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   in_valid/in_ready    - token handshake (transfer when both high)
//   in_type              - token kind (see encode_pkg::tok_e)
//   in_literal           - literal byte
//   in_offset/in_length  - match offset (1..2047) and length (2..2047)
//   cnt_output_enable    - registered: code word valid this cycle
//   cnt_output/cnt_len   - registered code bits (right-justified) and length
//   cnt_finish           - registered: end marker emitted, sticky until reset
module encode_code
  import encode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_type,
  input  logic [7:0]        in_literal,
  input  logic [OFF_W-1:0]  in_offset,
  input  logic [OFF_W-1:0]  in_length,
  output logic              cnt_output_enable,
  output logic [CODE_W-1:0] cnt_output,
  output logic [LEN_W-1:0]  cnt_len,
  output logic              cnt_finish
);

  state_e             r_state;
  logic [OFF_W-1:0]   r_length;
  logic [OFF_W-1:0]   r_rem;
  logic               r_end_pend;

  logic               w_accept;
  logic [CODE_W-1:0]  w_tok_code, w_len_code, w_ext_code;
  logic [LEN_W-1:0]   w_tok_bits, w_len_bits, w_ext_bits;

  // The cycle the end word is on the wire also refuses tokens, so nothing
  // slips in between the end marker and cnt_finish rising.
  assign in_ready = (r_state == ST_IDLE) && !cnt_finish && !r_end_pend;
  assign w_accept = in_valid && in_ready;

  // First word of an accepted token.
  always_comb begin
    w_tok_code = '0;
    w_tok_bits = '0;
    case (tok_e'(in_type))
      TOK_LIT: begin
        w_tok_code = {4'b0, LIT_PFX, in_literal};
        w_tok_bits = 4'd9;
      end
      TOK_MATCH: begin
        if (in_offset < 11'd128) begin
          w_tok_code = {4'b0, OFF7_PFX, in_offset[6:0]};
          w_tok_bits = 4'd9;
        end else begin
          w_tok_code = {OFF11_PFX, in_offset};
          w_tok_bits = 4'd13;
        end
      end
      TOK_END: begin
        w_tok_code = {4'b0, END_MARK};
        w_tok_bits = 4'd9;
      end
      default: ;
    endcase
  end

  // Length code emitted in LEN.
  always_comb begin
    w_len_code = '0;
    w_len_bits = '0;
    if (r_length <= 11'd4) begin
      w_len_code = {11'b0, 2'(r_length - 11'd2)};      // 00/01/10
      w_len_bits = 4'd2;
    end else if (r_length <= 11'd7) begin
      w_len_code = {9'b0, 4'(r_length + 11'd7)};       // 1100..1110
      w_len_bits = 4'd4;
    end else begin
      // E = length-8 saturates at 15; the overflow goes to EXT
      w_len_code = {5'b0, NIB_ONES,
                    (r_length >= EXT_MIN_LEN) ? NIB_ONES : 4'(r_length - 11'd8)};
      w_len_bits = 4'd8;
    end
  end

  // Extension word: R/15 is resolved by range compares since R < 45 here.
  always_comb begin
    w_ext_code = '0;
    w_ext_bits = '0;
    if (r_rem >= EXT_STEP) begin
      w_ext_code = {1'b0, {3{NIB_ONES}}};
      w_ext_bits = 4'd12;
    end else if (r_rem >= 11'd30) begin
      w_ext_code = {1'b0, NIB_ONES, NIB_ONES, 4'(r_rem - 11'd30)};
      w_ext_bits = 4'd12;
    end else if (r_rem >= 11'd15) begin
      w_ext_code = {5'b0, NIB_ONES, 4'(r_rem - 11'd15)};
      w_ext_bits = 4'd8;
    end else begin
      w_ext_code = {9'b0, r_rem[3:0]};
      w_ext_bits = 4'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= ST_IDLE;
      r_length          <= '0;
      r_rem             <= '0;
      r_end_pend        <= 1'b0;
      cnt_output_enable <= 1'b0;
      cnt_output        <= '0;
      cnt_len           <= '0;
      cnt_finish        <= 1'b0;
    end else begin
      cnt_output_enable <= 1'b0;
      cnt_output        <= '0;
      cnt_len           <= '0;
      if (r_end_pend) begin
        cnt_finish <= 1'b1;
        r_end_pend <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept && (tok_e'(in_type) != TOK_RSVD)) begin
            cnt_output_enable <= 1'b1;
            cnt_output        <= w_tok_code;
            cnt_len           <= w_tok_bits;
            if (tok_e'(in_type) == TOK_MATCH) begin
              r_length <= in_length;
              r_state  <= ST_LEN;
            end
            if (tok_e'(in_type) == TOK_END) r_end_pend <= 1'b1;
          end
        end
        ST_LEN: begin
          cnt_output_enable <= 1'b1;
          cnt_output        <= w_len_code;
          cnt_len           <= w_len_bits;
          if (r_length >= EXT_MIN_LEN) begin
            r_rem   <= r_length - EXT_MIN_LEN;   // R = E-15
            r_state <= ST_EXT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_EXT: begin
          cnt_output_enable <= 1'b1;
          cnt_output        <= w_ext_code;
          cnt_len           <= w_ext_bits;
          if (r_rem >= EXT_STEP) begin
            r_rem <= r_rem - EXT_STEP;
          end else begin
            r_rem   <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encode_code.sv
// tb_encode_code: scoreboard bench for encode_code. The driver pushes the
// expected code words (with the cycle each must appear) when a token is
// accepted; a negedge monitor pops and compares whatever the DUT emits.
module tb_encode_code;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_type;
  logic [7:0]  in_literal;
  logic [10:0] in_offset;
  logic [10:0] in_length;
  logic        cnt_output_enable;
  logic [12:0] cnt_output;
  logic [3:0]  cnt_len;
  logic        cnt_finish;

  always #5 clk = ~clk;

  encode_code dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_literal(in_literal), .in_offset(in_offset), .in_length(in_length),
    .cnt_output_enable(cnt_output_enable), .cnt_output(cnt_output),
    .cnt_len(cnt_len), .cnt_finish(cnt_finish)
  );

  typedef struct {
    int unsigned code;
    int unsigned len;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        tmp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned next_rdy = 0;
  bit          ended = 0;
  int unsigned end_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_w(input int unsigned code, input int unsigned len);
    exp_t e;
    e.code = code; e.len = len; e.cyc = 0;
    tmp_q.push_back(e);
  endtask

  // Reference model straight from the LZS code tables, plain arithmetic.
  task automatic model(input logic [1:0] t, input int lit, input int off, input int len);
    int e, r, k;
    tmp_q.delete();
    case (t)
      2'd0: push_w(lit, 9);
      2'd1: begin
        if (off < 128) push_w(3 * 128 + off, 9);
        else           push_w(2 * 2048 + off, 13);
        if (len <= 4)      push_w(len - 2, 2);
        else if (len <= 7) push_w(12 + (len - 5), 4);
        else begin
          e = len - 8;
          push_w(240 + ((e < 15) ? e : 15), 8);
          if (e >= 15) begin
            r = e - 15;
            while (r >= 45) begin
              push_w(4095, 12);
              r -= 45;
            end
            k = r / 15;
            push_w(((1 << (4 * k)) - 1) * 16 + (r - 15 * k), 4 * (k + 1));
          end
        end
      end
      2'd2: push_w(384, 9);
      default: ;
    endcase
  endtask

  // Drive one token; holds it until the DUT is ready (bounded), then
  // schedules the expected words relative to the accepting edge.
  task automatic send(input logic [1:0] t, input int lit, input int off, input int len,
                      input bit use_model);
    int unsigned c;
    int guard;
    if (use_model) model(t, lit, off, len);
    @(negedge clk);
    in_valid   = 1'b1;
    in_type    = t;
    in_literal = 8'(lit);
    in_offset  = 11'(off);
    in_length  = 11'(len);
    guard = 0;
    forever begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, (cyc >= next_rdy)});
      if (in_ready) break;
      guard++;
      if (guard > 500) begin
        chk("ready_timeout", 0, 1);
        in_valid = 1'b0;
        tmp_q.delete();
        return;
      end
      @(negedge clk);
    end
    c = cyc;
    foreach (tmp_q[i]) begin
      tmp_q[i].cyc = c + 1 + i;
      sb_q.push_back(tmp_q[i]);
    end
    next_rdy = c + ((tmp_q.size() == 0) ? 1 : tmp_q.size());
    if (t == 2'd2) begin
      ended   = 1'b1;
      end_cyc = c;
    end
    tmp_q.delete();
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Monitor: every cycle either a scheduled word or an all-zero idle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (cnt_output_enable) begin
        if (sb_q.size() == 0) chk("spurious_word", {19'b0, cnt_output}, 0);
        else begin
          e = sb_q.pop_front();
          chk("code", {19'b0, cnt_output}, e.code);
          chk("len", {28'b0, cnt_len}, e.len);
          chk("word_cycle", cyc, e.cyc);
        end
      end else begin
        chk("idle_code", {19'b0, cnt_output}, 0);
        chk("idle_len", {28'b0, cnt_len}, 0);
        if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
          chk("missing_word", 0, sb_q[0].code);
          void'(sb_q.pop_front());
        end
      end
      chk("finish", {31'b0, cnt_finish}, {31'b0, (ended && cyc >= end_cyc + 2)});
    end
  end

  initial begin
    int lens[15] = '{2, 4, 5, 7, 8, 22, 23, 37, 38, 52, 53, 67, 68, 69, 2047};
    int r, off, len;
    rst = 1'b1; in_valid = 1'b0; in_type = 2'b0;
    in_literal = 8'h0; in_offset = 11'h0; in_length = 11'h0;
    #2;
    chk("rst_enable", {31'b0, cnt_output_enable}, 0);
    chk("rst_code", {19'b0, cnt_output}, 0);
    chk("rst_len", {28'b0, cnt_len}, 0);
    chk("rst_finish", {31'b0, cnt_finish}, 0);
    chk("rst_ready", {31'b0, in_ready}, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Worked examples with constant expectations.
    tmp_q.delete(); push_w(12'h041, 9);
    send(2'd0, 8'h41, 0, 0, 1'b0);
    @(negedge clk);
    tmp_q.delete(); push_w(12'h185, 9); push_w(1, 2);
    send(2'd1, 0, 5, 3, 1'b0);
    tmp_q.delete(); push_w(13'h112C, 13); push_w(8'hF0, 8);
    send(2'd1, 0, 300, 8, 1'b0);
    tmp_q.delete(); push_w(12'h181, 9); push_w(8'hFF, 8); push_w(12'hFFF, 12); push_w(4'hC, 4);
    send(2'd1, 0, 1, 80, 1'b0);
    tmp_q.delete(); push_w(12'h181, 9); push_w(8'hFF, 8); push_w(12'hFFF, 12); push_w(0, 4);
    send(2'd1, 0, 1, 68, 1'b0);

    // Boundaries: offset split, length-code ranges, extension edges.
    send(2'd1, 0, 127, 2, 1'b1);
    send(2'd1, 0, 128, 2, 1'b1);
    send(2'd1, 0, 2047, 6, 1'b1);
    foreach (lens[i]) send(2'd1, 0, 1 + i, lens[i], 1'b1);
    for (int i = 0; i < 6; i++) send(2'd0, i * 37, 0, 0, 1'b1);  // back-to-back literals
    send(2'd3, 0, 0, 0, 1'b1);

    // Randomized tokens with gaps.
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      off = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 127) : $urandom_range(128, 2047);
      case ($urandom_range(0, 9))
        0:       len = $urandom_range(201, 2047);
        1, 2, 3: len = $urandom_range(31, 200);
        default: len = $urandom_range(2, 30);
      endcase
      if (r < 40)      send(2'd0, $urandom_range(0, 255), 0, 0, 1'b1);
      else if (r < 93) send(2'd1, 0, off, len, 1'b1);
      else             send(2'd3, 0, off, len, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_type = 2'($urandom);
      end
    end

    // Reset in the middle of a long match's extension words.
    send(2'd1, 0, 5, 200, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    sb_q.delete();
    next_rdy = 0;
    #1;
    chk("midrst_enable", {31'b0, cnt_output_enable}, 0);
    chk("midrst_code", {19'b0, cnt_output}, 0);
    chk("midrst_len", {28'b0, cnt_len}, 0);
    chk("midrst_ready", {31'b0, in_ready}, 1);
    @(negedge clk);
    rst = 1'b0;
    send(2'd0, 8'h5A, 0, 0, 1'b1);
    send(2'd1, 0, 9, 4, 1'b1);

    // End marker, then further tokens must be refused.
    tmp_q.delete(); push_w(12'h180, 9);
    send(2'd2, 0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_type = 2'd0; in_literal = 8'(i);
      chk("ready_after_end", {31'b0, in_ready}, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("leftover_words", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/encode_code.md
ENCODE_CODE -- requirements
Module: encode_code

Interface
REQ-001 clk  input  1  clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 in_valid  input  1  token present on in_* this cycle.
REQ-004 in_ready  output  1  block accepts a token this cycle; transfer when in_valid && in_ready.
REQ-005 in_type  input  2  token kind: 00 literal, 01 match, 10 end, 11 reserved (ignored, accepted, no output).
REQ-006 in_literal  input  8  literal byte, valid when in_type=00.
REQ-007 in_offset  input  11  match offset, 1..2047, valid when in_type=01; 0 is illegal.
REQ-008 in_length  input  11  match length, 2..2047, valid when in_type=01.
REQ-009 cnt_output_enable  output  1  registered; code word on cnt_output/cnt_len is valid this cycle.
REQ-010 cnt_output  output  13  registered code bits, right-justified in [cnt_len-1:0], MSB first on the wire, unused upper bits 0.
REQ-011 cnt_len  output  4  registered code length, 2..13 when enable=1, 0 otherwise.
REQ-012 cnt_finish  output  1  registered; end marker emitted, held high until reset.

Function
REQ-013 The block SHALL convert literal/match/end tokens into LZS code words for the downstream bit packer, at most one code word per cycle, with no backpressure from downstream.
REQ-014 Latency SHALL be one cycle: a token accepted at cycle N produces its first code word at N+1.
REQ-015 in_ready SHALL be (state==IDLE) && !cnt_finish; it is combinational from registered state only.
REQ-016 FSM states: IDLE, LEN, EXT; literal and end tokens stay in IDLE; a match goes IDLE->LEN->IDLE or IDLE->LEN->EXT(...)->IDLE.
REQ-017 Literal SHALL emit {0, byte}, 9 bits; back-to-back literals sustain one per cycle.
REQ-018 Match offset < 128 SHALL emit {11, offset[6:0]}, 9 bits; offset >= 128 SHALL emit {10, offset[10:0]}, 13 bits.
REQ-019 In LEN, length code SHALL be: 2->00, 3->01, 4->10 (2 bits); 5->1100, 6->1101, 7->1110 (4 bits); >=8 -> {1111, min(E,15)} (8 bits) with E = length-8.
REQ-020 LEN SHALL return to IDLE unless E >= 15, in which case remainder R = E-15 is loaded and the FSM enters EXT.
REQ-021 In EXT: if R >= 45, emit 12 ones (len 12), R -= 45, stay; else k = R/15 (0..2), emit k nibbles 1111 then nibble R-15k, len 4(k+1), go IDLE.
REQ-022 R = 45 exactly SHALL produce a 12-ones word followed by a 0000 (len 4) word.
REQ-023 End token SHALL emit 110000000 (9 bits); cnt_finish SHALL rise the following cycle and stay high; in_ready then stays 0.
REQ-024 cnt_output_enable SHALL be 0 in any cycle without a code word; cnt_output and cnt_len SHALL then be 0.
REQ-025 Division by 15 in EXT SHALL use compare/subtract (R < 45), no divider.

Reset
REQ-026 During/after rst: state=IDLE, R=0, cnt_output_enable=0, cnt_output=0, cnt_len=0, cnt_finish=0, in_ready=1.
REQ-027 rst asserted mid-match (LEN or EXT) SHALL abort the token immediately; no further code words for it.

Structure
REQ-028 Token-type encodings, LZS prefix constants, end-marker value and FSM state encodings SHALL live in shared package encode_pkg.
REQ-029 No sub-module; the length/extension encoder stays inline.

Verification
REQ-030 Literal 0x41 -> one cycle later cnt_output=0x041, cnt_len=9, enable=1; next cycle enable=0.
REQ-031 Match offset 5, length 3 -> 0x185/len 9, then 0x1/len 2; in_ready low for one cycle.
REQ-032 Match offset 300, length 8 -> 0x112C/len 13, then 0xF0/len 8.
REQ-033 Match offset 1, length 80 -> 0x181/9, 0xFF/8, 0xFFF/12, 0xC/4; in_ready high again after the last word.
REQ-034 Match length 68 (R=45) -> after the offset word: 0xFF/8, 0xFFF/12, 0x0/4.
REQ-035 End token -> 0x180/len 9, cnt_finish=1 the next cycle; further in_valid ignored; rst during EXT of a length-200 match -> all outputs 0 at once, in_ready=1.
